m_mem_access_unit: RTL

- Memory-stage consumer of the E→M pipeline register outputs: the ALU result address, RD2 store data and the decoded memory op.
- Turns one M-stage load/store into a req/ack transaction on the data bus.
- Holds the pipeline with `stall` until the access completes, then presents the byte/halfword/word-extended load result for the M→W register.
- Flags misaligned accesses and bus timeouts for the exception logic.

---
 rtl/cpu_defs.sv | 53 +++++
 rtl/m_mem_access_unit_load_ext.sv | 30 +++
 rtl/m_mem_access_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory-op codes (also used by the decoder), memory-stage
// FSM state encodings, byte-enable constants and small op-classification helpers.
package cpu_defs;

    localparam logic [3:0] MEMOP_NONE = 4'd0;
    localparam logic [3:0] MEMOP_LW   = 4'd1;
    localparam logic [3:0] MEMOP_LH   = 4'd2;
    localparam logic [3:0] MEMOP_LHU  = 4'd3;
    localparam logic [3:0] MEMOP_LB   = 4'd4;
    localparam logic [3:0] MEMOP_LBU  = 4'd5;
    localparam logic [3:0] MEMOP_SW   = 4'd6;
    localparam logic [3:0] MEMOP_SH   = 4'd7;
    localparam logic [3:0] MEMOP_SB   = 4'd8;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEMOP_LW) || (op == MEMOP_LH) || (op == MEMOP_LHU) ||
               (op == MEMOP_LB) || (op == MEMOP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEMOP_SW) || (op == MEMOP_SH) || (op == MEMOP_SB);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            MEMOP_LW, MEMOP_SW:            return a != 2'b00;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: return a[0];
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [3:0] op, input logic [1:0] a);
        case (op)
            MEMOP_LW, MEMOP_SW:              return BE_WORD;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH:   return a[1] ? BE_HALF_HI : BE_HALF_LO;
            MEMOP_LB, MEMOP_LBU, MEMOP_SB:   return BE_BYTE0 << a;
            default:                         return BE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/m_mem_access_unit_load_ext.sv
// Load-result lane selection and sign/zero extension; stores and NONE yield zero
// so a completed store never leaks bus data into the M->W register.
module m_load_ext
    import cpu_defs::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o = '0;
        case (op_i)
            MEMOP_LW:  data_o = rdata_i;
            MEMOP_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            MEMOP_LHU: data_o = {16'h0000, half_sel};
            MEMOP_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_LBU: data_o = {24'h000000, byte_sel};
            default:   data_o = '0;
        endcase
    end

endmodule

// File: rtl/m_mem_access_unit.sv
// Memory-stage access unit: runs one load/store as a req/ack bus transaction,
// stalls the pipeline until completion and reports misalignment / bus timeout.
module m_mem_access_unit
    import cpu_defs::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_Valid,
    input  logic [3:0]  M_MemOp,
    input  logic [31:0] M_ALUResult,
    input  logic [31:0] M_RD2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err
);

    mem_state_e        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              adel_q, adel_d;
    logic              ades_q, ades_d;
    logic              berr_q, berr_d;
    logic [31:0]       wdata_lanes;
    logic [31:0]       ext_data;

    m_load_ext u_load_ext (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (mem_rdata),
        .data_o    (ext_data)
    );

    // Replicate narrow store data on every lane so the byte enables alone pick the target.
    always_comb begin
        case (M_MemOp)
            MEMOP_SB: wdata_lanes = {4{M_RD2[7:0]}};
            MEMOP_SH: wdata_lanes = {2{M_RD2[15:0]}};
            default:  wdata_lanes = M_RD2;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        ld_data_d = '0;
        adel_d    = 1'b0;
        ades_d    = 1'b0;
        berr_d    = 1'b0;
        stall     = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (M_Valid && (is_load(M_MemOp) || is_store(M_MemOp))) begin
                    stall   = 1'b1;
                    op_d    = M_MemOp;
                    addr_d  = M_ALUResult;
                    be_d    = byte_enables(M_MemOp, M_ALUResult[1:0]);
                    wdata_d = wdata_lanes;
                    cnt_d   = '0;
                    if (is_misaligned(M_MemOp, M_ALUResult[1:0])) begin
                        state_d = MEM_DONE;
                        adel_d  = is_load(M_MemOp);
                        ades_d  = is_store(M_MemOp);
                    end else begin
                        state_d = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                stall = 1'b1;
                if (mem_ack) begin
                    ld_data_d = ext_data;
                    state_d   = MEM_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d = MEM_DONE;
                        berr_d  = 1'b1;
                    end
                end
            end
            MEM_DONE: state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MEM_IDLE;
            op_q      <= MEMOP_NONE;
            addr_q    <= '0;
            be_q      <= BE_NONE;
            wdata_q   <= '0;
            cnt_q     <= '0;
            ld_data_q <= '0;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            adel_q    <= adel_d;
            ades_q    <= ades_d;
            berr_q    <= berr_d;
        end
    end

    assign mem_req   = (state_q == MEM_REQ);
    assign mem_we    = mem_req && is_store(op_q);
    assign mem_be    = mem_req ? be_q : BE_NONE;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign done      = (state_q == MEM_DONE);
    assign ld_data   = ld_data_q;
    assign exc_adel  = adel_q;
    assign exc_ades  = ades_q;
    assign bus_err   = berr_q;

endmodule
